// File: rtl/fsrc_sched_pkg.sv
// Shared types and constants for the FSRC ctrl scheduler.
// The entry layout and pointer widths live here so the table and the
// sequencing logic agree on one definition.
package fsrc_sched_pkg;

    localparam int SCHED_CTRL_W    = 40;
    localparam int SCHED_COUNTER_W = 4;
    localparam int SCHED_TRIG_W    = 4;
    localparam int SCHED_DEPTH     = 8;
    localparam int SCHED_PTR_W     = $clog2(SCHED_DEPTH);
    localparam int SCHED_CNT_W     = SCHED_PTR_W + 1;

    localparam logic [SCHED_CNT_W-1:0] SCHED_DEPTH_CNT = SCHED_CNT_W'(SCHED_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsrc_sched_state_e;

    typedef struct packed {
        logic [SCHED_CTRL_W-1:0]    ctrl;
        logic [SCHED_COUNTER_W-1:0] cnt;
        logic [SCHED_TRIG_W-1:0]    mask;
    } fsrc_sched_entry_t;

endpackage

// File: rtl/fsrc_sched_table.sv
// Program table for the FSRC ctrl scheduler.
// Entries are appended at address entry_count; clear rewinds the fill
// pointer without scrubbing contents. Three combinational read ports
// serve the pending entry, its successor and entry 0 (for restarts).
module fsrc_sched_table
    import fsrc_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic                   i_clear_en,
    input  fsrc_sched_entry_t      i_wr_entry,
    input  logic [SCHED_PTR_W-1:0] i_rd_idx,
    output logic [SCHED_CNT_W-1:0] o_entry_count,
    output fsrc_sched_entry_t      o_rd_cur,
    output fsrc_sched_entry_t      o_rd_next,
    output fsrc_sched_entry_t      o_rd_first
);

    localparam logic [SCHED_CNT_W-1:0] LP_CNT_ONE = {{(SCHED_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SCHED_PTR_W-1:0] LP_PTR_ONE = {{(SCHED_PTR_W-1){1'b0}}, 1'b1};

    fsrc_sched_entry_t      r_mem [SCHED_DEPTH];
    logic [SCHED_CNT_W-1:0] r_entry_count;
    logic [SCHED_PTR_W-1:0] w_next_idx;

    // Append accepted writes and rewind the fill pointer on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry_count <= {SCHED_CNT_W{1'b0}};
            for (int i = 0; i < SCHED_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear_en) begin
            r_entry_count <= {SCHED_CNT_W{1'b0}};
        end else if (i_wr_en) begin
            r_mem[r_entry_count[SCHED_PTR_W-1:0]] <= i_wr_entry;
            r_entry_count                         <= r_entry_count + LP_CNT_ONE;
        end else begin
            r_entry_count <= r_entry_count;
        end
    end

    // The successor index wraps naturally because DEPTH is a power of two.
    always_comb begin
        w_next_idx = i_rd_idx + LP_PTR_ONE;
    end

    assign o_entry_count = r_entry_count;
    assign o_rd_cur      = r_mem[i_rd_idx];
    assign o_rd_next     = r_mem[w_next_idx];
    assign o_rd_first    = r_mem[0];

endmodule

// File: rtl/fsrc_ctrl_scheduler.sv
// Sysref-aligned playback engine for FSRC control words.
// Steps through the program table, counting sysref rising edges per entry,
// and on the apply edge registers the entry's ctrl word and pulses its
// trigger mask for one cycle.
module fsrc_ctrl_scheduler
    import fsrc_sched_pkg::*;
#(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4,
    parameter int DEPTH         = 8
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sysref,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       clear,
    input  logic                       loop_en,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [CTRL_WIDTH-1:0]      wr_ctrl,
    input  logic [COUNTER_WIDTH-1:0]   wr_cnt,
    input  logic [NUM_TRIG-1:0]        wr_trig_mask,
    output logic [CTRL_WIDTH-1:0]      ctrl,
    output logic [NUM_TRIG-1:0]        trig_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     entry_count,
    output logic [$clog2(DEPTH)-1:0]   cur_idx
);

    localparam logic [SCHED_CNT_W-1:0]     LP_CNT_ONE = {{(SCHED_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SCHED_PTR_W-1:0]     LP_PTR_ONE = {{(SCHED_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [SCHED_COUNTER_W-1:0] LP_REM_ONE = {{(SCHED_COUNTER_W-1){1'b0}}, 1'b1};

    fsrc_sched_state_e          r_state;
    fsrc_sched_state_e          w_state_nxt;
    logic                       r_sysref_d;
    logic                       w_edge;
    logic [SCHED_PTR_W-1:0]     r_cur_idx;
    logic [SCHED_PTR_W-1:0]     w_cur_idx_nxt;
    logic [SCHED_COUNTER_W-1:0] r_rem;
    logic [SCHED_COUNTER_W-1:0] w_rem_nxt;
    logic [SCHED_CTRL_W-1:0]    r_ctrl;
    logic [SCHED_CTRL_W-1:0]    w_ctrl_nxt;
    logic [SCHED_TRIG_W-1:0]    r_trig;
    logic [SCHED_TRIG_W-1:0]    w_trig_nxt;
    logic                       r_done;
    logic                       w_done_nxt;

    logic [SCHED_CNT_W-1:0]     w_entry_count;
    logic                       w_start_go;
    logic                       w_clear_en;
    logic                       w_wr_en;
    logic                       w_wr_ready;
    logic                       w_is_last;
    fsrc_sched_entry_t          w_wr_entry;
    fsrc_sched_entry_t          w_cur_entry;
    fsrc_sched_entry_t          w_next_entry;
    fsrc_sched_entry_t          w_first_entry;

    // Table-side handshake: writes only in IDLE, never alongside start, never
    // when full. Clear beats a same-cycle write; a taken start suppresses clear
    // so playback never begins on an emptied table.
    always_comb begin
        w_start_go = (r_state == IDLE) & start & (w_entry_count != {SCHED_CNT_W{1'b0}});
        w_wr_ready = (r_state == IDLE) & ~start & (w_entry_count < SCHED_DEPTH_CNT);
        w_clear_en = (r_state == IDLE) & clear & ~w_start_go;
        w_wr_en    = wr_valid & w_wr_ready & ~clear;
        w_edge     = sysref & ~r_sysref_d;
        w_is_last  = ({1'b0, r_cur_idx} == (w_entry_count - LP_CNT_ONE));
        w_wr_entry = '{ctrl: wr_ctrl, cnt: wr_cnt, mask: wr_trig_mask};
    end

    fsrc_sched_table u_table (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (w_wr_en),
        .i_clear_en    (w_clear_en),
        .i_wr_entry    (w_wr_entry),
        .i_rd_idx      (r_cur_idx),
        .o_entry_count (w_entry_count),
        .o_rd_cur      (w_cur_entry),
        .o_rd_next     (w_next_entry),
        .o_rd_first    (w_first_entry)
    );

    // Playback sequencing: edge counting, apply, advance/loop/finish, abort.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_idx_nxt = r_cur_idx;
        w_rem_nxt     = r_rem;
        w_ctrl_nxt    = r_ctrl;
        w_trig_nxt    = {SCHED_TRIG_W{1'b0}};
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_go) begin
                    w_state_nxt   = RUN;
                    w_cur_idx_nxt = {SCHED_PTR_W{1'b0}};
                    w_rem_nxt     = w_first_entry.cnt;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_edge) begin
                    if (r_rem != {SCHED_COUNTER_W{1'b0}}) begin
                        w_rem_nxt = r_rem - LP_REM_ONE;
                    end else begin
                        w_ctrl_nxt = w_cur_entry.ctrl;
                        w_trig_nxt = w_cur_entry.mask;
                        if (!w_is_last) begin
                            w_cur_idx_nxt = r_cur_idx + LP_PTR_ONE;
                            w_rem_nxt     = w_next_entry.cnt;
                        end else if (loop_en) begin
                            w_cur_idx_nxt = {SCHED_PTR_W{1'b0}};
                            w_rem_nxt     = w_first_entry.cnt;
                        end else begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, sysref history and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sysref_d <= 1'b0;
            r_cur_idx  <= {SCHED_PTR_W{1'b0}};
            r_rem      <= {SCHED_COUNTER_W{1'b0}};
            r_ctrl     <= {SCHED_CTRL_W{1'b0}};
            r_trig     <= {SCHED_TRIG_W{1'b0}};
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sysref_d <= sysref;
            r_cur_idx  <= w_cur_idx_nxt;
            r_rem      <= w_rem_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_trig     <= w_trig_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign wr_ready    = w_wr_ready;
    assign ctrl        = r_ctrl;
    assign trig_out    = r_trig;
    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign entry_count = w_entry_count;
    assign cur_idx     = r_cur_idx;

endmodule

// File: tb/tb_fsrc_ctrl_scheduler.sv
// Directed bench for fsrc_ctrl_scheduler: a behavioural model (table as
// arrays, playback as "edges seen since the entry became pending") checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_fsrc_ctrl_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sysref = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [39:0] wr_ctrl = 40'h0;
    logic [3:0]  wr_cnt = 4'h0;
    logic [3:0]  wr_trig_mask = 4'h0;
    logic [39:0] ctrl;
    logic [3:0]  trig_out;
    logic        busy;
    logic        done;
    logic [3:0]  entry_count;
    logic [2:0]  cur_idx;

    int n_vec = 0;
    int n_err = 0;

    fsrc_ctrl_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .sysref       (sysref),
        .start        (start),
        .abort        (abort),
        .clear        (clear),
        .loop_en      (loop_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_ctrl      (wr_ctrl),
        .wr_cnt       (wr_cnt),
        .wr_trig_mask (wr_trig_mask),
        .ctrl         (ctrl),
        .trig_out     (trig_out),
        .busy         (busy),
        .done         (done),
        .entry_count  (entry_count),
        .cur_idx      (cur_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [39:0] m_tab_ctrl [8];
    int          m_tab_cnt  [8];
    logic [3:0]  m_tab_mask [8];
    int          m_count = 0;
    bit          m_run = 0;
    int          m_idx = 0;
    int          m_seen = 0;
    logic [39:0] m_ctrl = 40'h0;
    logic [3:0]  m_trig = 4'h0;
    bit          m_done = 0;
    bit          m_sd = 0;

    always @(posedge clk) begin
        bit edge_s;
        edge_s = sysref && !m_sd;
        if (reset) begin
            m_sd = 0; m_count = 0; m_run = 0; m_idx = 0; m_seen = 0;
            m_ctrl = 40'h0; m_trig = 4'h0; m_done = 0;
        end else begin
            m_sd   = sysref;
            m_trig = 4'h0;
            m_done = 0;
            if (!m_run) begin
                if (start && m_count > 0) begin
                    m_run = 1; m_idx = 0; m_seen = 0;
                end else if (clear) begin
                    m_count = 0;
                end else if (wr_valid && !start && m_count < 8) begin
                    m_tab_ctrl[m_count] = wr_ctrl;
                    m_tab_cnt[m_count]  = int'(wr_cnt);
                    m_tab_mask[m_count] = wr_trig_mask;
                    m_count++;
                end
            end else if (abort) begin
                m_run = 0;
            end else if (edge_s) begin
                if (m_seen == m_tab_cnt[m_idx]) begin
                    m_ctrl = m_tab_ctrl[m_idx];
                    m_trig = m_tab_mask[m_idx];
                    m_seen = 0;
                    if (m_idx == m_count - 1) begin
                        if (loop_en) m_idx = 0;
                        else begin m_run = 0; m_done = 1; end
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_seen++;
                end
            end
        end
    end

    // Per-cycle comparison, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("ctrl", 64'(ctrl), 64'(m_ctrl));
        chk("trig_out", 64'(trig_out), 64'(m_trig));
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(m_done));
        chk("entry_count", 64'(entry_count), 64'(m_count));
        chk("wr_ready", 64'(wr_ready), 64'(!m_run && !start && m_count < 8));
        if (m_run) chk("cur_idx", 64'(cur_idx), 64'(m_idx));
    end

    // ---------------- stimulus ----------------
    task automatic wr_entry(input logic [39:0] c, input logic [3:0] n, input logic [3:0] m);
        wr_valid = 1'b1; wr_ctrl = c; wr_cnt = n; wr_trig_mask = m;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic sref_edge();
        sysref = 1'b1; @(negedge clk); sysref = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        gap(3);
        reset = 1'b0;
        chk("rst_ctrl", 64'(ctrl), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_count", 64'(entry_count), 64'h0);
        chk("rst_trig", 64'(trig_out), 64'h0);

        // Three-step program, sysref period 16 clk.
        wr_entry(40'hA, 4'd0, 4'h1);
        wr_entry(40'hB, 4'd2, 4'h2);
        wr_entry(40'hC, 4'd1, 4'h4);
        chk("t1_count", 64'(entry_count), 64'h3);
        pulse_start();
        chk("t1_busy", 64'(busy), 64'h1);
        for (int e = 1; e <= 6; e++) begin
            sref_edge();
            if (e == 1) begin
                chk("t1_ctrl_a", 64'(ctrl), 64'hA);
                chk("t1_trig_a", 64'(trig_out), 64'h1);
            end else if (e == 4) begin
                chk("t1_ctrl_b", 64'(ctrl), 64'hB);
                chk("t1_trig_b", 64'(trig_out), 64'h2);
            end else if (e == 6) begin
                chk("t1_ctrl_c", 64'(ctrl), 64'hC);
                chk("t1_trig_c", 64'(trig_out), 64'h4);
                chk("t1_done", 64'(done), 64'h1);
                chk("t1_busy_end", 64'(busy), 64'h0);
            end else begin
                chk("t1_trig_idle", 64'(trig_out), 64'h0);
            end
            gap(15);
        end
        chk("t1_done_gone", 64'(done), 64'h0);

        // Fill the table to capacity; a ninth write must bounce.
        pulse_clear();
        chk("t2_cleared", 64'(entry_count), 64'h0);
        for (int i = 0; i < 8; i++) wr_entry(40'h100 + 40'(i), 4'(i), 4'h1);
        chk("t2_full_ready", 64'(wr_ready), 64'h0);
        chk("t2_full_count", 64'(entry_count), 64'h8);
        wr_valid = 1'b1; @(negedge clk); wr_valid = 1'b0;
        chk("t2_ninth", 64'(entry_count), 64'h8);

        // Looping two-entry program, then let it finish.
        pulse_clear();
        wr_entry(40'h11, 4'd0, 4'h1);
        wr_entry(40'h22, 4'd0, 4'h2);
        loop_en = 1'b1;
        pulse_start();
        for (int e = 0; e < 6; e++) begin
            sref_edge();
            chk("t3_ctrl", 64'(ctrl), (e % 2 == 1) ? 64'h22 : 64'h11);
            chk("t3_idx", 64'(cur_idx), (e % 2 == 1) ? 64'h0 : 64'h1);
            chk("t3_busy", 64'(busy), 64'h1);
            gap(3);
        end
        sref_edge();
        chk("t3_ctrl7", 64'(ctrl), 64'h11);
        loop_en = 1'b0;
        gap(3);
        sref_edge();
        chk("t3_ctrl8", 64'(ctrl), 64'h22);
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_busy_end", 64'(busy), 64'h0);
        gap(3);

        // Abort on the same cycle as an apply edge.
        pulse_start();
        gap(2);
        sysref = 1'b1; abort = 1'b1;
        @(negedge clk);
        sysref = 1'b0; abort = 1'b0;
        chk("t4_ctrl", 64'(ctrl), 64'h22);
        chk("t4_trig", 64'(trig_out), 64'h0);
        chk("t4_done", 64'(done), 64'h0);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_count", 64'(entry_count), 64'h2);
        gap(3);

        // Clear and start ignored in RUN; reset mid-RUN; start on empty table.
        pulse_start();
        pulse_clear();
        chk("t5_clear_ign", 64'(entry_count), 64'h2);
        chk("t5_busy", 64'(busy), 64'h1);
        pulse_start();
        sref_edge();
        chk("t5_ctrl", 64'(ctrl), 64'h11);
        gap(2);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("t5_rst_ctrl", 64'(ctrl), 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_count", 64'(entry_count), 64'h0);
        pulse_start();
        gap(3);
        chk("t5_empty_busy", 64'(busy), 64'h0);
        chk("t5_empty_ctrl", 64'(ctrl), 64'h0);
        gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsrc_ctrl_scheduler.md
Name: fsrc_ctrl_scheduler

Overview:
- Sysref-aligned playback engine for FSRC control words.
- Software loads a small program table of {ctrl value, sysref delay, trigger mask} entries. On start, the block steps through the table, applying each ctrl word and pulsing the selected triggers on a counted sysref rising edge.
- Sits between the sequencer register map and the FSRC datapath, in the same clk domain as the tx FSRC control logic. It replaces single-shot ctrl changes with timed multi-step schedules.

Parameters:
- CTRL_WIDTH, 40, width of the ctrl word driven to the FSRC datapath
- COUNTER_WIDTH, 4, width of the per-entry sysref delay count
- NUM_TRIG, 4, number of trigger outputs
- DEPTH, 8, program table entries (power of 2, >=2)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- sysref  in  1  sysref, already synchronous to clk
- start  in  1  pulse; begin playback from entry 0
- abort  in  1  pulse; stop playback immediately
- clear  in  1  pulse; empty the program table (honoured in IDLE only)
- loop_en  in  1  1 = restart at entry 0 after the last entry
- wr_valid  in  1  table write request
- wr_ready  out  1  table write accepted when wr_valid & wr_ready
- wr_ctrl  in  CTRL_WIDTH  entry ctrl value
- wr_cnt  in  COUNTER_WIDTH  entry delay in sysref edges
- wr_trig_mask  in  NUM_TRIG  triggers to pulse when the entry applies
- ctrl  out  CTRL_WIDTH  registered ctrl word
- trig_out  out  NUM_TRIG  1-cycle trigger pulses
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse at natural end of a non-looping program
- entry_count  out  $clog2(DEPTH)+1  number of programmed entries
- cur_idx  out  $clog2(DEPTH)  index of the entry currently pending

Behaviour:
- Reset values:
  - ctrl=0, trig_out=0, busy=0, done=0, entry_count=0, cur_idx=0.
  - State=IDLE; the sysref history register is cleared to 0.
- Sysref edge: edge = sysref & ~sysref_d, where sysref_d is registered.
- Table loading:
  - wr_ready = (state==IDLE) & ~start & (entry_count<DEPTH), combinational.
  - An accepted write stores the entry at address entry_count, and entry_count increments at the same edge.
  - When entry_count==DEPTH, wr_ready=0 and further writes are not accepted.
  - clear in IDLE sets entry_count=0 the next cycle; table contents need not be zeroed.
  - clear outside IDLE is ignored. clear and an accepted write in the same cycle: clear wins and the write is dropped.
- FSM states: IDLE, RUN.
  - IDLE: start with entry_count==0 is ignored.
  - IDLE to RUN: on start with entry_count>0. Set cur_idx=0 and rem=entry[0].cnt; busy=1 from the next cycle.
  - RUN, edge with rem!=0: rem decrements.
  - RUN, edge with rem==0 (apply): the next cycle has ctrl=entry[cur_idx].ctrl and trig_out=entry[cur_idx].mask for exactly 1 cycle. A delay of N therefore applies on the (N+1)th sysref edge after the entry becomes pending; latency from the edge cycle to ctrl change is 1 clk.
  - Same edge as an apply, more entries remain: cur_idx increments and rem loads the next entry's cnt.
  - Same edge as an apply, last entry, loop_en=1: cur_idx=0, rem=entry[0].cnt, stay in RUN. loop_en is sampled at the apply of the last entry.
  - Same edge as an apply, last entry, loop_en=0: go to IDLE, done pulses 1 cycle coincident with the final ctrl update.
- abort in RUN: IDLE next cycle; ctrl holds its last applied value, trig_out=0, no done pulse, table preserved.
- Simultaneous events:
  - abort with an apply edge: abort wins and nothing is applied.
  - start in RUN is ignored.
  - start and abort in IDLE: start wins.
- reset at any time, including mid-RUN, restores all reset values; the table is emptied (entry_count=0).
- ctrl changes only on apply or reset.

Decomposition:
- Package fsrc_sched_pkg:
  - state enum: IDLE, RUN.
  - packed struct fsrc_sched_entry_t {ctrl, cnt, mask}, parameterised via localparams mirrored from the top.
  - Constant for the pointer width.
- Sub-module fsrc_sched_table:
  - DEPTH x entry register array with write port and entry_count.
  - Clear logic and combinational read at cur_idx.
- Top level holds the FSM, edge detect, rem counter and output registers.

Test Plan:
- Reset, then write 3 entries {0xA,cnt 0,mask 1},{0xB,cnt 2,mask 2},{0xC,cnt 1,mask 4}, start, sysref period 16 clk:
  - ctrl=0xA one clk after edge 1, 0xB after edge 4, 0xC after edge 6.
  - trig_out pulses 1, 2, 4 at those cycles.
  - done pulses with 0xC; busy drops.
- Write 8 entries: wr_ready=0 after the 8th; a 9th wr_valid is not accepted; entry_count=8.
- loop_en=1, 2 entries with cnt 0:
  - ctrl alternates on every sysref edge for 6 edges and cur_idx wraps 1 to 0.
  - Deassert loop_en before an apply of entry 1: the block ends after that apply with a done pulse.
- abort asserted in the same cycle as an apply edge: ctrl unchanged, trig_out=0, no done, IDLE next cycle, entry_count unchanged.
- Synchronous reset mid-RUN, then start with an empty table: ctrl=0, busy stays 0.
- start with entry_count=0: no state change. clear during RUN: ignored, entry_count unchanged.
